// File: rtl/hazard_detection_unit_if.sv
// Purpose : bundles the pipeline-side hazard inputs and the stall/flush/MDU controls.
// Latency : wires only, no state.
// Backpressure : none here; stall and flush outputs are carried back to the pipeline as plain signals.
//
// Port summary
//   master : pipeline side, drives the ID/EX/MEM hazard fields and observes the controls
//   slave  : hazard unit side, reads the hazard fields and drives the controls
interface hazard_detection_unit_if;
  // Instruction currently in ID
  logic [4:0]  IF_ID_Rs;
  logic [4:0]  IF_ID_Rt;
  logic        IF_ID_UsesRt;
  logic        IF_ID_Branch;
  logic        IF_ID_Jump;
  logic        BranchTaken;
  logic        IF_ID_MDUStart;
  logic        IF_ID_ReadsHiLo;
  // Instruction currently in EX
  logic        ID_EX_MemRead;
  logic        ID_EX_RegWrite;
  logic [4:0]  ID_EX_Rd;
  // Instruction currently in MEM
  logic        EX_MEM_MemRead;
  logic [4:0]  EX_MEM_Rd;
  // Pipeline controls
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;
  logic        MDU_Start;
  logic        MDU_Busy;
  logic [15:0] StallCount;

  modport master (
    output IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_Branch, IF_ID_Jump, BranchTaken,
           IF_ID_MDUStart, IF_ID_ReadsHiLo,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd,
           EX_MEM_MemRead, EX_MEM_Rd,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Start, MDU_Busy, StallCount
  );

  modport slave (
    input  IF_ID_Rs, IF_ID_Rt, IF_ID_UsesRt, IF_ID_Branch, IF_ID_Jump, BranchTaken,
           IF_ID_MDUStart, IF_ID_ReadsHiLo,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_Rd,
           EX_MEM_MemRead, EX_MEM_Rd,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Start, MDU_Busy, StallCount
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// Purpose : detects load-use, branch-operand and HI/LO hazards, sequences the mult/div unit.
// Latency : stall/flush/start controls are combinational in the same cycle; state updates on clk.
// Backpressure : STALL freezes PC and IF/ID and injects a bubble into ID/EX; stall beats flush.
//
// Ports
//   clk   : system clock, all state on rising edge
//   reset : synchronous, active-low; while low the pipeline is frozen and flushed
//   hdu   : hazard_detection_unit_if.slave, ID/EX/MEM hazard fields in, pipeline controls out
module hazard_detection_unit #(
  parameter int MDU_LATENCY = 4   // EX cycles a mult/div occupies, 2..15
) (
  input  logic                   clk,
  input  logic                   reset,
  hazard_detection_unit_if.slave hdu
);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  // The counter holds the remaining busy cycles after the current one, so
  // loading LATENCY-1 yields exactly MDU_LATENCY cycles in MDU_WAIT.
  localparam logic [3:0] CNT_LOAD = 4'(MDU_LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q;

  logic lu_hazard;
  logic br_hazard;
  logic md_hazard;
  logic stall;
  logic mdu_start;

  // Hazard terms. Register 0 is hard-wired zero, so it never creates a dependency.
  always_comb begin
    lu_hazard = hdu.ID_EX_MemRead && (hdu.ID_EX_Rd != 5'd0) &&
                ((hdu.ID_EX_Rd == hdu.IF_ID_Rs) ||
                 (hdu.IF_ID_UsesRt && (hdu.ID_EX_Rd == hdu.IF_ID_Rt)));

    // Branches compare in ID, so an ALU result still in EX or a load result
    // still in MEM cannot be forwarded in time.
    br_hazard = 1'b0;
    if (hdu.IF_ID_Branch) begin
      if (hdu.ID_EX_RegWrite && (hdu.ID_EX_Rd != 5'd0) &&
          ((hdu.ID_EX_Rd == hdu.IF_ID_Rs) || (hdu.ID_EX_Rd == hdu.IF_ID_Rt)))
        br_hazard = 1'b1;
      if (hdu.EX_MEM_MemRead && (hdu.EX_MEM_Rd != 5'd0) &&
          ((hdu.EX_MEM_Rd == hdu.IF_ID_Rs) || (hdu.EX_MEM_Rd == hdu.IF_ID_Rt)))
        br_hazard = 1'b1;
    end

    // While the MDU is busy, HI/LO readers and new mult/div must wait.
    md_hazard = (state_q == MDU_WAIT) && (hdu.IF_ID_ReadsHiLo || hdu.IF_ID_MDUStart);

    stall = lu_hazard || br_hazard || md_hazard;
  end

  // FSM next state and start pulse
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mdu_start = 1'b0;
    case (state_q)
      RUN: begin
        // A stalled mult/div is not started; it retries next cycle.
        if (hdu.IF_ID_MDUStart && !stall) begin
          mdu_start = 1'b1;
          cnt_d     = CNT_LOAD;
          state_d   = MDU_WAIT;
        end
      end
      MDU_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= RUN;
      cnt_q         <= 4'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  // Pipeline controls. Reset forces a frozen, fully flushed pipeline no matter
  // what the hazard inputs say.
  always_comb begin
    hdu.PCWrite     = 1'b0;
    hdu.IF_ID_Write = 1'b0;
    hdu.IF_ID_Flush = 1'b1;
    hdu.ID_EX_Flush = 1'b1;
    hdu.MDU_Start   = 1'b0;
    hdu.MDU_Busy    = 1'b0;
    if (reset) begin
      hdu.MDU_Busy = (state_q == MDU_WAIT);
      if (stall) begin
        // A taken branch waits for clean operands before redirecting fetch.
        hdu.PCWrite     = 1'b0;
        hdu.IF_ID_Write = 1'b0;
        hdu.IF_ID_Flush = 1'b0;
        hdu.ID_EX_Flush = 1'b1;
        hdu.MDU_Start   = 1'b0;
      end else begin
        hdu.PCWrite     = 1'b1;
        hdu.IF_ID_Write = 1'b1;
        hdu.IF_ID_Flush = (hdu.IF_ID_Branch && hdu.BranchTaken) || hdu.IF_ID_Jump;
        hdu.ID_EX_Flush = 1'b0;
        hdu.MDU_Start   = mdu_start;
      end
    end
  end

  assign hdu.StallCount = stall_count_q;

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic clk;
  logic reset;

  hazard_detection_unit_if bus ();

  hazard_detection_unit #(.MDU_LATENCY(4)) dut (
    .clk   (clk),
    .reset (reset),
    .hdu   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs, rt;
    logic       uses_rt, branch, jump, taken, mdu_start, reads_hilo;
    logic       ex_memread, ex_regwrite;
    logic [4:0] ex_rd;
    logic       mem_memread;
    logic [4:0] mem_rd;
  } stim_t;

  // Expected control vector packing: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Start, MDU_Busy}
  typedef struct {
    logic [5:0]  ctl;
    logic [15:0] sc;
    string       name;
  } exp_t;

  localparam logic [5:0] RUNO   = 6'b110000;
  localparam logic [5:0] STALLO = 6'b000100;
  localparam logic [5:0] RSTO   = 6'b001100;
  localparam logic [5:0] FLUSHO = 6'b111000;
  localparam logic [5:0] STARTO = 6'b110010;
  localparam logic [5:0] BUSYO  = 6'b110001;
  localparam logic [5:0] MDSTL  = 6'b000101;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic stim_t nop();
    stim_t s;
    s.rst_n = 1'b1; s.rs = 5'd0; s.rt = 5'd0; s.uses_rt = 1'b0; s.branch = 1'b0;
    s.jump = 1'b0; s.taken = 1'b0; s.mdu_start = 1'b0; s.reads_hilo = 1'b0;
    s.ex_memread = 1'b0; s.ex_regwrite = 1'b0; s.ex_rd = 5'd0;
    s.mem_memread = 1'b0; s.mem_rd = 5'd0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset               = s.rst_n;
    bus.IF_ID_Rs        = s.rs;
    bus.IF_ID_Rt        = s.rt;
    bus.IF_ID_UsesRt    = s.uses_rt;
    bus.IF_ID_Branch    = s.branch;
    bus.IF_ID_Jump      = s.jump;
    bus.BranchTaken     = s.taken;
    bus.IF_ID_MDUStart  = s.mdu_start;
    bus.IF_ID_ReadsHiLo = s.reads_hilo;
    bus.ID_EX_MemRead   = s.ex_memread;
    bus.ID_EX_RegWrite  = s.ex_regwrite;
    bus.ID_EX_Rd        = s.ex_rd;
    bus.EX_MEM_MemRead  = s.mem_memread;
    bus.EX_MEM_Rd       = s.mem_rd;
  endtask

  // One cycle of stimulus plus its expected response for the monitor.
  task automatic apply(input stim_t s, input logic [5:0] ctl, input logic [15:0] sc, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    drive(s);
    e.ctl = ctl; e.sc = sc; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: samples on the falling edge, away from the state updates.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [5:0] got;
      e   = exp_q.pop_front();
      got = {bus.PCWrite, bus.IF_ID_Write, bus.IF_ID_Flush, bus.ID_EX_Flush, bus.MDU_Start, bus.MDU_Busy};
      n_cmp++;
      if (got !== e.ctl || bus.StallCount !== e.sc) begin
        n_bad++;
        $display("FAIL %s: ctl got %b want %b, StallCount got %h want %h",
                 e.name, got, e.ctl, bus.StallCount, e.sc);
      end
    end
  end

  initial begin
    stim_t s;
    int    guard;
    s = nop();
    s.rst_n = 1'b0;
    drive(s);
    repeat (2) @(posedge clk);

    // Reset: frozen and flushed regardless of hazard inputs
    apply(s, RSTO, 16'd0, "reset_idle");
    s.ex_memread = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8; s.mdu_start = 1'b1;
    apply(s, RSTO, 16'd0, "reset_with_hazard");
    s = nop();
    apply(s, RUNO, 16'd0, "run_after_reset");

    // Load-use on rs
    s = nop(); s.ex_memread = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8;
    apply(s, STALLO, 16'd0, "loaduse_rs_stall");
    s = nop(); s.rs = 5'd8;
    apply(s, RUNO, 16'd1, "loaduse_rs_release");
    // rt match but rt unused -> no stall
    s = nop(); s.ex_memread = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd3; s.rt = 5'd8; s.uses_rt = 1'b0;
    apply(s, RUNO, 16'd1, "loaduse_rt_unused");
    s.uses_rt = 1'b1;
    apply(s, STALLO, 16'd1, "loaduse_rt_used");
    s = nop();
    apply(s, RUNO, 16'd2, "loaduse_rt_release");
    // register 0 never a hazard
    s = nop(); s.ex_memread = 1'b1; s.ex_rd = 5'd0; s.rs = 5'd0; s.rt = 5'd0; s.uses_rt = 1'b1;
    apply(s, RUNO, 16'd2, "loaduse_r0");

    // Branch after ALU op: stall, then flush when clean
    s = nop(); s.branch = 1'b1; s.taken = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd9; s.rs = 5'd9;
    apply(s, STALLO, 16'd2, "branch_alu_stall");
    s.ex_regwrite = 1'b0; s.ex_rd = 5'd0;
    apply(s, FLUSHO, 16'd3, "branch_taken_flush");
    s = nop();
    apply(s, RUNO, 16'd3, "after_branch");
    // Branch rt vs load in MEM
    s = nop(); s.branch = 1'b1; s.taken = 1'b0; s.rs = 5'd1; s.rt = 5'd5; s.mem_memread = 1'b1; s.mem_rd = 5'd5;
    apply(s, STALLO, 16'd3, "branch_mem_load_stall");
    s.mem_memread = 1'b0;
    apply(s, RUNO, 16'd4, "branch_not_taken");
    s = nop(); s.jump = 1'b1;
    apply(s, FLUSHO, 16'd4, "jump_flush");
    s = nop(); s.branch = 1'b1; s.taken = 1'b1; s.ex_regwrite = 1'b1; s.ex_rd = 5'd0;
    apply(s, FLUSHO, 16'd4, "branch_r0_no_stall");

    // MDU: mult starts, then 4 busy cycles; mflo waits until busy falls
    s = nop(); s.mdu_start = 1'b1;
    apply(s, STARTO, 16'd4, "mdu_start");
    s = nop();
    apply(s, BUSYO, 16'd4, "mdu_busy_nonhilo");
    s = nop(); s.reads_hilo = 1'b1;
    apply(s, MDSTL, 16'd4, "mflo_stall1");
    apply(s, MDSTL, 16'd5, "mflo_stall2");
    apply(s, MDSTL, 16'd6, "mflo_stall3");
    apply(s, RUNO, 16'd7, "mflo_proceeds");

    // Back-to-back mult stalled, then reset in the second busy cycle
    s = nop(); s.mdu_start = 1'b1;
    apply(s, STARTO, 16'd7, "mdu_restart");
    apply(s, MDSTL, 16'd7, "mult_during_busy");
    s = nop(); s.rst_n = 1'b0; s.mdu_start = 1'b1;
    apply(s, RSTO, 16'd8, "reset_mid_mdu");
    s = nop();
    apply(s, RUNO, 16'd0, "mdu_aborted");

    // Stall beats MDU start
    s = nop(); s.ex_memread = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8; s.mdu_start = 1'b1;
    apply(s, STALLO, 16'd0, "stall_blocks_start");
    s = nop();
    apply(s, RUNO, 16'd1, "no_busy_after_blocked");

    // Saturation: continuous load-use stall well past 65535 edges
    s = nop(); s.ex_memread = 1'b1; s.ex_rd = 5'd8; s.rs = 5'd8;
    apply(s, STALLO, 16'd1, "sat_begin");
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      #1;
      drive(s);
    end
    apply(s, STALLO, 16'hFFFF, "sat_hold");
    apply(s, STALLO, 16'hFFFF, "sat_hold2");
    s = nop();
    apply(s, RUNO, 16'hFFFF, "sat_idle");
    s.rst_n = 1'b0;
    apply(s, RSTO, 16'hFFFF, "sat_reset");
    s.rst_n = 1'b1;
    apply(s, RUNO, 16'd0, "sat_cleared");

    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_detection_unit.md
HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter MDU_LATENCY, default 4, number of EX cycles a mult/div occupies (range 2..15).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port IF_ID_Rs  input  5  rs field of the instruction in ID.
REQ-005 SHALL have port IF_ID_Rt  input  5  rt field of the instruction in ID.
REQ-006 SHALL have port IF_ID_UsesRt  input  1  the instruction in ID reads rt as a source.
REQ-007 SHALL have port IF_ID_Branch  input  1  the instruction in ID is beq/bne, compared in ID.
REQ-008 SHALL have port IF_ID_Jump  input  1  the instruction in ID is j/jal.
REQ-009 SHALL have port BranchTaken  input  1  ID comparator result, meaningful only when IF_ID_Branch=1.
REQ-010 SHALL have port IF_ID_MDUStart  input  1  the instruction in ID is mult/multu/div/divu.
REQ-011 SHALL have port IF_ID_ReadsHiLo  input  1  the instruction in ID is mfhi/mflo.
REQ-012 SHALL have port ID_EX_MemRead  input  1  load in EX.
REQ-013 SHALL have port ID_EX_RegWrite  input  1  the instruction in EX writes a register.
REQ-014 SHALL have port ID_EX_Rd  input  5  destination register of the instruction in EX, after the RegDst mux.
REQ-015 SHALL have port EX_MEM_MemRead  input  1  load in MEM.
REQ-016 SHALL have port EX_MEM_Rd  input  5  destination register of the instruction in MEM.
REQ-017 SHALL have port PCWrite  output  1  enables the PC update.
REQ-018 SHALL have port IF_ID_Write  output  1  enables the IF/ID register load.
REQ-019 SHALL have port IF_ID_Flush  output  1  clears IF/ID to a nop.
REQ-020 SHALL have port ID_EX_Flush  output  1  loads a bubble (all control signals 0) into ID/EX.
REQ-021 SHALL have port MDU_Start  output  1  one-cycle start pulse to the multiply/divide unit.
REQ-022 SHALL have port MDU_Busy  output  1  multiply/divide operation in flight.
REQ-023 SHALL have port StallCount  output  16  saturating count of stall cycles since reset.

Function
REQ-024 SHALL compute the stall condition STALL as the OR of LU, BR and MD (REQ-025..027); register 0 never matches as a hazard.
REQ-025 LU: ID_EX_MemRead=1, ID_EX_Rd!=0, and (ID_EX_Rd==IF_ID_Rs or (IF_ID_UsesRt=1 and ID_EX_Rd==IF_ID_Rt)).
REQ-026 BR: IF_ID_Branch=1 and a branch operand (rs or rt) !=0 matches either ID_EX_Rd with ID_EX_RegWrite=1, or EX_MEM_Rd with EX_MEM_MemRead=1.
REQ-027 MD: state MDU_WAIT and (IF_ID_ReadsHiLo=1 or IF_ID_MDUStart=1).
REQ-028 When STALL=1: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0, MDU_Start=0; these outputs are combinational within the same cycle.
REQ-029 When STALL=0: PCWrite=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=1 if (IF_ID_Branch and BranchTaken) or IF_ID_Jump, else 0.
REQ-030 Stall takes precedence over flush; a taken branch is acted on only in the first cycle its operands are hazard-free.
REQ-031 SHALL implement FSM states RUN and MDU_WAIT, held in a register with a 4-bit down-counter CNT.
REQ-032 RUN: if IF_ID_MDUStart=1 and STALL=0, then MDU_Start=1 for that cycle, CNT<=MDU_LATENCY-1, and next state MDU_WAIT.
REQ-033 MDU_WAIT: CNT decrements by 1 each cycle; the cycle CNT==0 returns to RUN; a mult/div in ID is stalled (MD), not started.
REQ-034 MDU_Busy SHALL be 1 exactly while the state is MDU_WAIT, i.e. MDU_LATENCY cycles after the MDU_Start cycle.
REQ-035 Non-HI/LO instructions SHALL proceed unstalled during MDU_WAIT.
REQ-036 StallCount SHALL increment by 1 on each rising edge where STALL=1 and saturate at 16'hFFFF without wrapping.

Reset
REQ-037 With reset=0 at a rising edge: state<=RUN, CNT<=0, StallCount<=0.
REQ-038 While reset=0: PCWrite=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, MDU_Start=0, MDU_Busy=0, regardless of the other inputs.
REQ-039 Reset asserted mid-MDU_WAIT SHALL abort the operation; MDU_Busy=0 from the next cycle on.

Verification
REQ-040 Load-use: ID_EX_MemRead=1, ID_EX_Rd=8, IF_ID_Rs=8 -> exactly 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; StallCount 0->1.
REQ-041 Rt not used: same as REQ-040 but match on IF_ID_Rt with IF_ID_UsesRt=0 -> no stall; with ID_EX_Rd=0 -> no stall.
REQ-042 Branch after ALU op: IF_ID_Branch=1, BranchTaken=1, ID_EX_RegWrite=1, ID_EX_Rd=IF_ID_Rs=9 -> 1 stall cycle with IF_ID_Flush=0, then IF_ID_Flush=1 for 1 cycle.
REQ-043 MDU: mult in ID with MDU_LATENCY=4 -> MDU_Start pulse, MDU_Busy=1 for 4 cycles; mflo issued 1 cycle later -> stalled 3 cycles, proceeds when MDU_Busy falls.
REQ-044 Reset mid-MDU: reset=0 during cycle 2 of MDU_WAIT -> MDU_Busy=0, StallCount=0, and all flush outputs=1 while reset=0.
REQ-045 Saturation: force 65536+ stall cycles -> StallCount holds at 16'hFFFF.
